// File: rtl/dp_ram_sync.sv
`default_nettype none
// ============================================================================
// Module   : dp_ram_sync
// Brief    : True dual-port synchronous RAM with registered reads, a valid
//            strobe per port, port-A-wins write collisions and an optional
//            reset-time clear sequence.
// Revision : 1.0 - initial release
// ============================================================================
module dp_ram_sync #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] address_a,
    input  logic [DATA_WIDTH-1:0] data_in_a,
    input  logic                  write_enable_a,
    input  logic                  read_enable_a,
    output logic [DATA_WIDTH-1:0] data_out_a,
    output logic                  valid_a,
    input  logic [ADDR_WIDTH-1:0] address_b,
    input  logic [DATA_WIDTH-1:0] data_in_b,
    input  logic                  write_enable_b,
    input  logic                  read_enable_b,
    output logic [DATA_WIDTH-1:0] data_out_b,
    output logic                  valid_b,
    output logic                  init_done,
    output logic                  collision
);

    localparam int                    c_depth     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_last_addr = {ADDR_WIDTH{1'b1}};

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam state_t c_reset_state = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_clr_addr;
    logic [ADDR_WIDTH-1:0] w_clr_addr_next;
    logic [DATA_WIDTH-1:0] r_mem [c_depth];

    logic [DATA_WIDTH-1:0] r_data_out_a;
    logic [DATA_WIDTH-1:0] r_data_out_b;
    logic                  r_valid_a;
    logic                  r_valid_b;
    logic                  r_collision;

    logic                  w_ready;
    logic                  w_clearing;
    logic                  w_same_addr;
    logic                  w_wr_a;
    logic                  w_wr_b;
    logic                  w_rd_a;
    logic                  w_rd_b;
    logic                  w_collide;
    logic [DATA_WIDTH-1:0] w_rdata_a;
    logic [DATA_WIDTH-1:0] w_rdata_b;

    // ------------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_reset_state;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_next;
            r_clr_addr <= w_clr_addr_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_clr_addr_next = r_clr_addr;
        case (r_state)
            ST_CLEAR: begin
                w_clr_addr_next = r_clr_addr + ADDR_WIDTH'(1);
                if (r_clr_addr == c_last_addr) begin
                    w_state_next = ST_READY;
                end
            end
            default: begin
                w_state_next = ST_READY;
            end
        endcase
    end

    // Requests are honoured only in READY and never in a reset cycle.
    assign w_ready     = (r_state == ST_READY);
    assign w_clearing  = (r_state == ST_CLEAR) && !rst;
    assign w_same_addr = (address_a == address_b);
    assign w_wr_a      = w_ready && !rst && write_enable_a;
    assign w_wr_b      = w_ready && !rst && write_enable_b && !(w_wr_a && w_same_addr);
    assign w_rd_a      = w_ready && !rst && read_enable_a;
    assign w_rd_b      = w_ready && !rst && read_enable_b;
    assign w_collide   = w_wr_a && write_enable_b && w_same_addr;

    // ------------------------------------------------------------------------
    // Storage array (untouched by rst itself)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_clearing) begin
            r_mem[r_clr_addr] <= '0;
        end
        if (w_wr_a) begin
            r_mem[address_a] <= data_in_a;
        end
        if (w_wr_b) begin
            r_mem[address_b] <= data_in_b;
        end
    end

    // ------------------------------------------------------------------------
    // Read-during-write selection; port A data is the "new" word on collision
    // ------------------------------------------------------------------------
    generate
        if (RDW_MODE != 0) begin : g_write_first
            always_comb begin
                w_rdata_a = r_mem[address_a];
                if (w_wr_a) begin
                    w_rdata_a = data_in_a;
                end else if (w_wr_b && w_same_addr) begin
                    w_rdata_a = data_in_b;
                end
            end

            always_comb begin
                w_rdata_b = r_mem[address_b];
                if (w_wr_a && w_same_addr) begin
                    w_rdata_b = data_in_a;
                end else if (w_wr_b) begin
                    w_rdata_b = data_in_b;
                end
            end
        end else begin : g_read_first
            assign w_rdata_a = r_mem[address_a];
            assign w_rdata_b = r_mem[address_b];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out_a <= '0;
            r_data_out_b <= '0;
            r_valid_a    <= 1'b0;
            r_valid_b    <= 1'b0;
            r_collision  <= 1'b0;
        end else begin
            r_valid_a   <= w_rd_a;
            r_valid_b   <= w_rd_b;
            r_collision <= w_collide;
            if (w_rd_a) begin
                r_data_out_a <= w_rdata_a;
            end
            if (w_rd_b) begin
                r_data_out_b <= w_rdata_b;
            end
        end
    end

    assign data_out_a = r_data_out_a;
    assign data_out_b = r_data_out_b;
    assign valid_a    = r_valid_a;
    assign valid_b    = r_valid_b;
    assign collision  = r_collision;
    assign init_done  = w_ready;

endmodule
`default_nettype wire

// File: tb/tb_dp_ram_sync.sv
`default_nettype none
// Bench for dp_ram_sync: a default instance (read-first, clear on reset) and a
// 32x64 write-first instance without clear, both checked against one array model.
module tb_dp_ram_sync;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  addr_a, addr_b;
    logic [31:0] din_a, din_b;
    logic        we_a, we_b, re_a, re_b;

    logic [7:0]  d0_a, d0_b;
    logic        v0_a, v0_b, init0, coll0;
    logic [31:0] d1_a, d1_b;
    logic        v1_a, v1_b, init1, coll1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dp_ram_sync u_dut0 (
        .clk(clk), .rst(rst),
        .address_a(addr_a[3:0]), .data_in_a(din_a[7:0]), .write_enable_a(we_a),
        .read_enable_a(re_a), .data_out_a(d0_a), .valid_a(v0_a),
        .address_b(addr_b[3:0]), .data_in_b(din_b[7:0]), .write_enable_b(we_b),
        .read_enable_b(re_b), .data_out_b(d0_b), .valid_b(v0_b),
        .init_done(init0), .collision(coll0)
    );

    dp_ram_sync #(
        .DATA_WIDTH(32), .ADDR_WIDTH(6), .RDW_MODE(1), .CLEAR_ON_RESET(0)
    ) u_dut1 (
        .clk(clk), .rst(rst),
        .address_a(addr_a), .data_in_a(din_a), .write_enable_a(we_a),
        .read_enable_a(re_a), .data_out_a(d1_a), .valid_a(v1_a),
        .address_b(addr_b), .data_in_b(din_b), .write_enable_b(we_b),
        .read_enable_b(re_b), .data_out_b(d1_b), .valid_b(v1_b),
        .init_done(init1), .collision(coll1)
    );

    // ------------------------------------------------------------------------
    // Behavioural model: index 0 = default instance, 1 = wide write-first one
    // ------------------------------------------------------------------------
    logic [31:0] m_mem    [2][64];
    bit          m_known  [2][64];
    bit          m_ready  [2];
    int          m_clr    [2];
    logic [31:0] e_dout   [2][2];
    bit          e_dknown [2][2];
    bit          e_valid  [2][2];
    bit          e_coll   [2];
    bit          started = 1'b0;

    function automatic int depth_of(input int k);
        return (k == 0) ? 16 : 64;
    endfunction

    function automatic logic [31:0] mask_of(input int k);
        return (k == 0) ? 32'h0000_00FF : 32'hFFFF_FFFF;
    endfunction

    task automatic model_step(input int k);
        int          dep;
        int          aa, ab, x;
        logic [31:0] da, db;
        bit          rdw, rq;
        dep = depth_of(k);
        rdw = (k == 1);
        aa  = int'(addr_a) % dep;
        ab  = int'(addr_b) % dep;
        da  = din_a & mask_of(k);
        db  = din_b & mask_of(k);
        if (rst) begin
            m_ready[k] = (k == 1);
            m_clr[k]   = 0;
            e_coll[k]  = 1'b0;
            for (int p = 0; p < 2; p++) begin
                e_valid[k][p]  = 1'b0;
                e_dout[k][p]   = '0;
                e_dknown[k][p] = 1'b1;
            end
            return;
        end
        if (!m_ready[k]) begin
            m_mem[k][m_clr[k]]   = '0;
            m_known[k][m_clr[k]] = 1'b1;
            m_clr[k]++;
            if (m_clr[k] == dep) m_ready[k] = 1'b1;
            e_valid[k][0] = 1'b0;
            e_valid[k][1] = 1'b0;
            e_coll[k]     = 1'b0;
            return;
        end
        for (int p = 0; p < 2; p++) begin
            x  = (p == 0) ? aa : ab;
            rq = (p == 0) ? re_a : re_b;
            e_valid[k][p] = rq;
            if (rq) begin
                if (rdw && we_a && aa == x) begin
                    e_dout[k][p] = da;  e_dknown[k][p] = 1'b1;
                end else if (rdw && we_b && ab == x) begin
                    e_dout[k][p] = db;  e_dknown[k][p] = 1'b1;
                end else begin
                    e_dout[k][p]   = m_mem[k][x];
                    e_dknown[k][p] = m_known[k][x];
                end
            end
        end
        e_coll[k] = we_a && we_b && (aa == ab);
        if (we_b) begin m_mem[k][ab] = db; m_known[k][ab] = 1'b1; end
        if (we_a) begin m_mem[k][aa] = da; m_known[k][aa] = 1'b1; end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
        started = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(input int k, input logic ini, input logic col,
                            input logic va, input logic vb,
                            input logic [31:0] da, input logic [31:0] db);
        check($sformatf("dut%0d init_done", k), {31'b0, ini}, {31'b0, m_ready[k]});
        check($sformatf("dut%0d collision", k), {31'b0, col}, {31'b0, e_coll[k]});
        check($sformatf("dut%0d valid_a", k), {31'b0, va}, {31'b0, e_valid[k][0]});
        check($sformatf("dut%0d valid_b", k), {31'b0, vb}, {31'b0, e_valid[k][1]});
        if (e_dknown[k][0]) check($sformatf("dut%0d data_out_a", k), da, e_dout[k][0]);
        if (e_dknown[k][1]) check($sformatf("dut%0d data_out_b", k), db, e_dout[k][1]);
    endtask

    always @(negedge clk) begin
        if (started) begin
            cmp_inst(0, init0, coll0, v0_a, v0_b, {24'b0, d0_a}, {24'b0, d0_b});
            cmp_inst(1, init1, coll1, v1_a, v1_b, d1_a, d1_b);
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus (inputs change only on the falling edge)
    // ------------------------------------------------------------------------
    task automatic idle();
        we_a = 1'b0; we_b = 1'b0; re_a = 1'b0; re_b = 1'b0;
    endtask

    task automatic op(input bit wa, input bit ra, input logic [5:0] aa, input logic [31:0] da,
                      input bit wb, input bit rb, input logic [5:0] ab, input logic [31:0] db);
        we_a = wa; re_a = ra; addr_a = aa; din_a = da;
        we_b = wb; re_b = rb; addr_b = ab; din_b = db;
        @(negedge clk);
    endtask

    // Counts falling edges with init_done low from the one where rst drops,
    // while hammering the ports with requests that must be ignored.
    task automatic count_clear(input string name);
        int n;
        n = 0;
        while (init0 == 1'b0 && n < 100) begin
            n++;
            op(1, 1, 6'd2, 32'hFF, 1, 1, 6'd4, 32'hEE);
        end
        idle();
        check(name, n, 16);
    endtask

    initial begin
        idle();
        addr_a = '0; addr_b = '0; din_a = '0; din_b = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("no-clear init_done", {31'b0, init1}, 32'd1);
        count_clear("clear length");

        // every word of the default instance reads back zero
        for (int i = 0; i < 16; i++) begin
            op(0, 1, 6'(i), 0, 0, 1, 6'(15 - i), 0);
            check("clear readback a", {24'b0, d0_a}, 32'h00);
            check("clear readback b", {24'b0, d0_b}, 32'h00);
            check("clear valid a", {31'b0, v0_a}, 32'd1);
        end
        idle();

        // write on A, read on B next cycle
        op(1, 0, 6'd3, 32'h5A, 0, 0, 6'd0, 0);
        op(0, 0, 6'd0, 0, 0, 1, 6'd3, 0);
        check("rw latency data", {24'b0, d0_b}, 32'h5A);
        check("rw latency valid", {31'b0, v0_b}, 32'd1);
        op(0, 0, 6'd0, 0, 0, 0, 6'd0, 0);
        check("valid single pulse", {31'b0, v0_b}, 32'd0);

        // read-during-write, writer on A then writer on B
        op(1, 0, 6'd7, 32'h11, 0, 0, 6'd0, 0);
        op(1, 1, 6'd7, 32'h22, 0, 1, 6'd7, 0);
        check("rdw0 same-port", {24'b0, d0_a}, 32'h11);
        check("rdw0 cross-port", {24'b0, d0_b}, 32'h11);
        check("rdw1 same-port", d1_a, 32'h22);
        check("rdw1 cross-port", d1_b, 32'h22);
        op(0, 1, 6'd7, 0, 1, 1, 6'd7, 32'h33);
        check("rdw0 b-writer", {24'b0, d0_a}, 32'h22);
        check("rdw1 b-writer", d1_b, 32'h33);

        // same-address write/write
        op(1, 0, 6'd9, 32'hAA, 1, 0, 6'd9, 32'hBB);
        check("collision pulse", {31'b0, coll0}, 32'd1);
        op(0, 1, 6'd9, 0, 0, 1, 6'd9, 0);
        check("collision cleared", {31'b0, coll0}, 32'd0);
        check("collision winner", {24'b0, d0_b}, 32'hAA);
        op(1, 1, 6'd9, 32'hCC, 1, 1, 6'd9, 32'hDD);
        check("collision rdw1 b", d1_b, 32'hCC);
        check("collision rdw0 b", {24'b0, d0_b}, 32'hAA);
        op(1, 0, 6'd10, 32'h01, 1, 0, 6'd11, 32'h02);
        check("no collision", {31'b0, coll0}, 32'd0);
        op(0, 1, 6'd10, 0, 0, 1, 6'd11, 0);
        check("dual write a", {24'b0, d0_a}, 32'h01);
        check("dual write b", {24'b0, d0_b}, 32'h02);

        // reset in the middle of a clear restarts the full sequence
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            op(1, 1, 6'd3, 32'hFF, 1, 1, 6'd5, 32'hEE);
            check("clear ignores read", {31'b0, v0_a}, 32'd0);
        end
        rst = 1'b1;
        idle();
        @(negedge clk);
        rst = 1'b0;
        count_clear("clear length after restart");
        op(0, 1, 6'd2, 0, 0, 1, 6'd4, 0);
        check("write during clear a", {24'b0, d0_a}, 32'h00);
        check("write during clear b", {24'b0, d0_b}, 32'h00);

        // wide instance, extreme addresses
        op(1, 0, 6'd63, 32'hDEADBEEF, 1, 0, 6'd0, 32'h12345678);
        op(0, 1, 6'd63, 0, 0, 1, 6'd0, 0);
        check("wide addr 63", d1_a, 32'hDEADBEEF);
        check("wide addr 0", d1_b, 32'h12345678);
        check("narrow addr 15", {24'b0, d0_a}, 32'hEF);
        idle();

        // randomized traffic, with occasional resets and hot-address bursts
        for (int i = 0; i < 3000; i++) begin
            bit hot;
            hot  = ($urandom_range(0, 3) == 0);
            rst  = ($urandom_range(0, 199) == 0);
            we_a = $urandom_range(0, 1) == 1;
            we_b = $urandom_range(0, 1) == 1;
            re_a = $urandom_range(0, 1) == 1;
            re_b = $urandom_range(0, 1) == 1;
            addr_a = hot ? 6'($urandom_range(0, 3)) : 6'($urandom_range(0, 63));
            addr_b = hot ? 6'($urandom_range(0, 3)) : 6'($urandom_range(0, 63));
            din_a  = $urandom;
            din_b  = $urandom;
            @(negedge clk);
        end
        rst = 1'b0;
        idle();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
